// File: rtl/incr_program_counter.sv
// -----------------------------------------------------------------------------
// incr_program_counter
//
// Free-running program-counter incrementer for the fetch stage. A WIDTH-bit
// PC register advances by INC_STEP on every rising clock edge and wraps
// modulo 2^WIDTH (the final carry-out is dropped, no overflow flag). The next
// value comes from a ripple-carry chain built from full-adder stages, running
// from the LSB (I[WIDTH-1]) up to the MSB (I[0]).
//
// Parameters
//   WIDTH     PC width in bits, 1..64
//   INC_STEP  constant increment per clock, < 2^WIDTH
//   RESET_PC  value loaded while reset is asserted, < 2^WIDTH
//
// Ports (positional order is fixed: I, clk, reset)
//   I      out [0:WIDTH-1]  current PC straight from the register; I[0] = MSB
//   clk    in               rising-edge clock
//   reset  in               asynchronous, active-low reset (0 = asserted)
// -----------------------------------------------------------------------------
module incr_program_counter #(
  parameter int          WIDTH    = 4,
  parameter logic [63:0] INC_STEP = 64'd1,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  output logic [0:WIDTH-1] I,
  input  logic             clk,
  input  logic             reset
);

  // Full-adder sum cell: a ^ b ^ cin.
  function automatic logic fa_sum(input logic a, input logic b, input logic cin);
    return a ^ b ^ cin;
  endfunction

  // Full-adder carry cell: majority(a, b, cin).
  function automatic logic fa_carry(input logic a, input logic b, input logic cin);
    return (a & b) | (a & cin) | (b & cin);
  endfunction

  // Constants re-ranged to the MSB-first bit order used by I, so bit k of
  // every vector below carries the same weight (2^(WIDTH-1-k)).
  localparam logic [0:WIDTH-1] STEP_C  = INC_STEP[WIDTH-1:0];
  localparam logic [0:WIDTH-1] RESET_C = RESET_PC[WIDTH-1:0];

  logic [0:WIDTH-1] pc_r;
  logic [0:WIDTH-1] next_s;
  // carry_s[k] is the carry into stage k-1; carry_s[WIDTH] feeds the LSB stage.
  // The carry out of the MSB stage is never formed, so the result wraps.
  logic [1:WIDTH]   carry_s;

  assign carry_s[WIDTH] = 1'b0;

  // Ripple chain: stage k adds pc_r[k] and STEP_C[k] with the carry from the
  // stage below it (k+1).
  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    assign next_s[k] = fa_sum(pc_r[k], STEP_C[k], carry_s[k+1]);
    if (k > 0) begin : g_carry
      assign carry_s[k] = fa_carry(pc_r[k], STEP_C[k], carry_s[k+1]);
    end
  end

  // PC register: asynchronous load of RESET_PC, otherwise advance every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_C;
    end else begin
      pc_r <= next_s;
    end
  end

  assign I = pc_r;

endmodule

// File: tb/tb_incr_program_counter.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_incr_program_counter
//
// Two instances share one clock: a default 4-bit counter (step 1, reset 0)
// and an 8-bit counter with step 4 and reset value 8'hF8. An independent
// model value is advanced on each rising edge and pushed to a scoreboard
// queue; each test pops it at the following falling edge and compares it
// against the DUT output.
// -----------------------------------------------------------------------------
module tb_incr_program_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset8;
  logic [0:3] pc4;
  logic [0:7] pc8;

  incr_program_counter #(.WIDTH(4), .INC_STEP(64'd1), .RESET_PC(64'd0)) dut4 (
    .I(pc4), .clk(clk), .reset(reset)
  );

  incr_program_counter #(.WIDTH(8), .INC_STEP(64'd4), .RESET_PC(64'hF8)) dut8 (
    .I(pc8), .clk(clk), .reset(reset8)
  );

  // Period-2 clock.
  always #1 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] model4;
  logic [7:0] model8;
  logic [3:0] sb4[$];
  logic [7:0] sb8[$];

  // Wait for a rising edge, advance the 4-bit model, queue the expectation.
  task automatic tick4();
    @(posedge clk);
    model4 = reset ? model4 + 4'd1 : 4'd0;
    sb4.push_back(model4);
  endtask

  // Wait for a rising edge, advance the 8-bit model, queue the expectation.
  task automatic tick8();
    @(posedge clk);
    model8 = reset8 ? model8 + 8'd4 : 8'hF8;
    sb8.push_back(model8);
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    // Hold reset low for 1000 time units, checking every cycle.
    for (int i = 0; i < 500; i++) begin
      tick4();
      @(negedge clk);
      exp = sb4.pop_front();
      vectors++;
      if (pc4 !== exp) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, pc4, exp);
      end
    end
    vectors++;
    if (pc8 !== 8'hF8) begin
      miscompares++;
      $display("FAIL reset_hold_w8: got %h expected f8", pc8);
    end
  endtask

  task automatic test_count();
    logic [3:0] exp;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick4();
      @(negedge clk);
      exp = sb4.pop_front();
      vectors++;
      if (pc4 !== exp) begin
        miscompares++;
        $display("FAIL count edge %0d: got %b expected %b", i, pc4, exp);
      end
      if (exp == 4'd1) begin
        vectors++;
        if (pc4[3] !== 1'b1 || pc4[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL bit_order_0001: got I[3]=%b I[0]=%b expected 1 0", pc4[3], pc4[0]);
        end
      end
      if (exp == 4'd8) begin
        vectors++;
        if (pc4[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL bit_order_1000: got I[0]=%b expected 1", pc4[0]);
        end
      end
    end
    vectors++;
    if (pc4 !== 4'b1010) begin
      miscompares++;
      $display("FAIL count_10th: got %b expected 1010", pc4);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp;
    logic       saw_ones;
    saw_ones = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model4 = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      tick4();
      @(negedge clk);
      exp = sb4.pop_front();
      vectors++;
      if (pc4 !== exp) begin
        miscompares++;
        $display("FAIL wrap edge %0d: got %b expected %b", i, pc4, exp);
      end
      if (pc4 === 4'b1111) saw_ones = 1'b1;
    end
    vectors++;
    if (pc4 !== 4'b0000 || !saw_ones) begin
      miscompares++;
      $display("FAIL wrap_end: got %b saw_1111=%b expected 0000 saw_1111=1", pc4, saw_ones);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp;
    // Count up to 0110 from the wrapped 0000.
    for (int i = 1; i <= 6; i++) begin
      tick4();
      @(negedge clk);
      exp = sb4.pop_front();
      vectors++;
      if (pc4 !== exp) begin
        miscompares++;
        $display("FAIL async_pre edge %0d: got %b expected %b", i, pc4, exp);
      end
    end
    vectors++;
    if (pc4 !== 4'b0110) begin
      miscompares++;
      $display("FAIL async_at_0110: got %b expected 0110", pc4);
    end
    // Assert reset midway between edges; output must clear before next posedge.
    #0.4;
    reset = 1'b0;
    model4 = 4'd0;
    #0.2;
    vectors++;
    if (pc4 !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_immediate: got %b expected 0000", pc4);
    end
    for (int i = 0; i < 4; i++) begin
      tick4();
      @(negedge clk);
      exp = sb4.pop_front();
      vectors++;
      if (pc4 !== exp) begin
        miscompares++;
        $display("FAIL async_hold cycle %0d: got %b expected %b", i, pc4, exp);
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick4();
      @(negedge clk);
      exp = sb4.pop_front();
      vectors++;
      if (pc4 !== exp) begin
        miscompares++;
        $display("FAIL async_restart edge %0d: got %b expected %b", i, pc4, exp);
      end
    end
  endtask

  task automatic test_param_w8();
    logic [7:0] exp;
    @(negedge clk);
    vectors++;
    if (pc8 !== 8'hF8) begin
      miscompares++;
      $display("FAIL w8_reset: got %h expected f8", pc8);
    end
    reset8 = 1'b1;
    model8 = 8'hF8;
    for (int i = 1; i <= 4; i++) begin
      tick8();
      @(negedge clk);
      exp = sb8.pop_front();
      vectors++;
      if (pc8 !== exp) begin
        miscompares++;
        $display("FAIL w8_count edge %0d: got %h expected %h", i, pc8, exp);
      end
      if (i == 2) begin
        vectors++;
        if (pc8 !== 8'h00) begin
          miscompares++;
          $display("FAIL w8_wrap: got %h expected 00", pc8);
        end
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    reset8 = 1'b0;
    model4 = 4'd0;
    model8 = 8'hF8;
    test_reset();
    test_count();
    test_wrap();
    test_async_reset();
    test_param_w8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
